fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, SHALL be the PC loaded on reset.
REQ-002 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 stall  input  1  SHALL, when 1, hold the IF/ID outputs and the PC (back-pressure from decode).
REQ-005 flush  input  1  SHALL, when 1, invalidate the IF/ID outputs on the next edge.
REQ-006 redirect  input  1  SHALL, when 1, replace the PC with redirect_pc (taken branch, J, JR).
REQ-007 redirect_pc  input  32  SHALL be the new fetch address; bits [1:0] are ignored and forced to 00.
REQ-008 imem_req / imem_addr  output  1 / 32  SHALL carry the instruction-memory read request and word address.
REQ-009 imem_ack / imem_rdata  input  1 / 32  SHALL signal read completion and the returned instruction (same cycle).
REQ-010 if_valid / if_instr / if_pc4  output  1 / 32 / 32  SHALL form the IF/ID register: valid flag, instruction, fetch address + 4.
REQ-011 op / fn  output  6 / 6  SHALL equal if_instr[31:26] / if_instr[5:0] combinationally, feeding the decoder.

Function
REQ-012 FSM states SHALL be REQ (request outstanding), HOLD (instruction buffered, decode stalled), KILL (discard outstanding response).
REQ-013 A fetch address register faddr SHALL drive imem_addr; imem_req and imem_addr SHALL remain stable from assertion until the imem_ack cycle.
REQ-014 REQ: imem_req=1; on imem_ack with stall=0: if_instr<=imem_rdata, if_pc4<=faddr+4, if_valid<=1, faddr<=faddr+4; stay REQ.
REQ-015 REQ: on imem_ack with stall=1: imem_rdata SHALL be captured into a one-entry buffer, faddr<=faddr+4, go HOLD.
REQ-016 REQ without imem_ack: if_valid<=0 when stall=0 (bubble); IF/ID unchanged when stall=1.
REQ-017 HOLD: imem_req=0; when stall=0, the buffer and its pc+4 SHALL load IF/ID with if_valid<=1; go REQ next cycle.
REQ-018 redirect SHALL have priority over stall and flush: faddr<=redirect_pc & ~3, if_valid<=0, buffer dropped.
REQ-019 redirect in REQ without imem_ack SHALL go KILL, keeping imem_req=1 and the old address until ack; that response is discarded, then faddr=redirect target and state=REQ.
REQ-020 redirect coincident with imem_ack SHALL discard imem_rdata and go REQ at the redirect target; redirect in HOLD SHALL go REQ.
REQ-021 redirect in KILL SHALL update the pending target only; the state stays KILL.
REQ-022 flush without redirect SHALL force if_valid<=0, override stall on the IF/ID register, and not alter faddr, state or buffer.
REQ-023 faddr+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-024 if_instr and if_pc4 SHALL hold their values when if_valid=0; consumers qualify with if_valid.

Reset
REQ-025 When reset=1 at an edge: faddr=RESET_PC, state=REQ, if_valid=0, if_instr=0, if_pc4=0, buffer empty.
REQ-026 imem_req SHALL be 0 while reset=1 and 1 in the first cycle after reset deasserts.
REQ-027 Reset mid-request SHALL abandon the outstanding access; a late imem_ack in the first post-reset cycle SHALL be ignored.

Verification
REQ-028 Reset, memory acks every cycle with instr=addr -> if_pc4 = 4, 8, 12...; if_valid=1 from the 2nd post-reset edge.
REQ-029 Ack latency 3 cycles -> two bubbles (if_valid=0) between valid instructions; imem_addr stable during wait.
REQ-030 stall=1 for 4 cycles on an acked fetch -> HOLD entered, imem_req=0, IF/ID frozen; release -> buffered instr then next fetch, none lost or duplicated.
REQ-031 redirect_pc=32'h00000103 during an outstanding fetch (latency 2) -> response discarded, next imem_addr=32'h00000100, no valid output for stale data.
REQ-032 faddr=32'hFFFFFFFC acked -> if_pc4=0, next imem_addr=0; flush+stall together -> if_valid=0 next cycle.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory read bus between the fetch stage (master) and memory (slave).
// req/addr are held stable by the master from assertion through the ack cycle.
// ack/rdata are returned by the slave in the same cycle.
interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: sequential PC, one outstanding memory read, and the
// IF/ID pipeline register.
// A one-entry buffer absorbs a response that arrives while decode is stalled (HOLD).
// A redirect while a read is in flight waits out that read and drops its data (KILL).
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  fetch_stage_if.master        imem,
  output logic                 if_valid,
  output logic [31:0]          if_instr,
  output logic [31:0]          if_pc4,
  output logic [5:0]           op,
  output logic [5:0]           fn
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_HOLD = 2'd1,
    ST_KILL = 2'd2
  } state_t;

  state_t      state_reg;
  logic [31:0] faddr_reg;
  logic [31:0] target_reg;
  logic [31:0] buf_instr_reg;
  logic [31:0] buf_pc4_reg;
  logic        if_valid_reg;
  logic [31:0] if_instr_reg;
  logic [31:0] if_pc4_reg;
  logic        ignore_ack_reg;

  logic [31:0] faddr_inc;
  logic [31:0] redirect_aligned;
  logic        ack_ok;

  // Sequential fetch address; the 32-bit add wraps naturally past 32'hFFFFFFFC.
  assign faddr_inc        = faddr_reg + 32'd4;
  assign redirect_aligned = redirect_pc & ~32'd3;
  // An ack in the first cycle after reset belongs to an abandoned pre-reset access.
  assign ack_ok           = imem.ack & ~ignore_ack_reg;

  // The request is gated with reset directly so it drops in the same cycle reset rises.
  assign imem.req  = ~reset & (state_reg != ST_HOLD);
  assign imem.addr = faddr_reg;

  assign if_valid = if_valid_reg;
  assign if_instr = if_instr_reg;
  assign if_pc4   = if_pc4_reg;
  assign op       = if_instr_reg[31:26];
  assign fn       = if_instr_reg[5:0];

  // Fetch FSM, fetch address, buffer and IF/ID register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= ST_REQ;
      faddr_reg      <= RESET_PC;
      target_reg     <= RESET_PC;
      buf_instr_reg  <= 32'd0;
      buf_pc4_reg    <= 32'd0;
      if_valid_reg   <= 1'b0;
      if_instr_reg   <= 32'd0;
      if_pc4_reg     <= 32'd0;
      ignore_ack_reg <= 1'b1;
    end else begin
      ignore_ack_reg <= 1'b0;
      if (redirect) begin
        // Redirect wins over stall and flush; the buffered instruction is abandoned.
        if_valid_reg <= 1'b0;
        case (state_reg)
          ST_REQ: begin
            if (ack_ok) begin
              faddr_reg <= redirect_aligned;
            end else begin
              // Keep the in-flight address on the bus until memory answers.
              target_reg <= redirect_aligned;
              state_reg  <= ST_KILL;
            end
          end
          ST_HOLD: begin
            faddr_reg <= redirect_aligned;
            state_reg <= ST_REQ;
          end
          ST_KILL: begin
            // Later redirect only retargets; the stale read is still pending.
            target_reg <= redirect_aligned;
          end
          default: begin
            state_reg <= ST_REQ;
          end
        endcase
      end else begin
        case (state_reg)
          ST_REQ: begin
            if (ack_ok) begin
              faddr_reg <= faddr_inc;
              if (stall) begin
                buf_instr_reg <= imem.rdata;
                buf_pc4_reg   <= faddr_inc;
                state_reg     <= ST_HOLD;
              end else begin
                if_instr_reg <= imem.rdata;
                if_pc4_reg   <= faddr_inc;
                if_valid_reg <= 1'b1;
              end
            end else if (!stall) begin
              if_valid_reg <= 1'b0;
            end
          end
          ST_HOLD: begin
            if (!stall) begin
              if_instr_reg <= buf_instr_reg;
              if_pc4_reg   <= buf_pc4_reg;
              if_valid_reg <= 1'b1;
              state_reg    <= ST_REQ;
            end
          end
          ST_KILL: begin
            if (ack_ok) begin
              faddr_reg <= target_reg;
              state_reg <= ST_REQ;
            end
          end
          default: begin
            state_reg <= ST_REQ;
          end
        endcase
        // Flush squashes the IF/ID entry even while decode is stalled.
        if (flush) begin
          if_valid_reg <= 1'b0;
        end
      end
    end
  end

endmodule
